test_monitor: RTL
=================

Name: test_monitor

Overview:
- Synthesizable end-of-test monitor for multi-hart twitchcore simulation and FPGA runs.
- Watches each hart's trap line and result signature, the low bytes of a0..a3 packed as four characters.
- Enforces a cycle-count timeout and reports an aggregate verdict: pass, fail or timeout.
- Sits beside the core array. Verdict outputs drive LEDs/UART on FPGA and are sampled by the bench to end a run.

Parameters:
- NUM_HARTS, 1, number of monitored harts (1..16)
- TIMEOUT_CYCLES, 5000, cycles in RUN before a timeout is declared
- CNT_W, 32, cycle counter width; must hold TIMEOUT_CYCLES
- PASS_SIG, 32'h4F4B0A00, signature meaning pass ("OK\n\0")
- FAIL_SIG, 32'h4572720A, signature meaning fail ("Err\n")

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: arm the monitor and clear all state
- trap  in  NUM_HARTS  per-hart trap/halt level
- sig  in  32*NUM_HARTS  per-hart signature {a0[7:0],a1[7:0],a2[7:0],a3[7:0]}; hart h at [32h+31:32h]
- hart_done  out  NUM_HARTS  hart has trapped and its result is latched
- hart_pass  out  NUM_HARTS  latched signature == PASS_SIG
- done  out  1  verdict valid; held until start or reset
- pass  out  1  all harts passed
- fail  out  1  at least one hart reported a non-PASS signature
- timeout  out  1  timeout expired before all harts trapped
- first_fail  out  4  index of the lowest-numbered failing hart
- cycles  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset: state=IDLE. All outputs are 0, including cycles and first_fail.
- States: IDLE, RUN, DONE.
- IDLE: start -> RUN next cycle; cycles, hart_done, hart_pass, first_fail and the flags clear on the same edge.
- RUN, each cycle:
  - cycles increments, saturating at all-ones.
  - For each hart with trap=1 and hart_done=0: set hart_done[h]; set hart_pass[h] = (sig_h == PASS_SIG).
  - A signature that matches neither PASS_SIG nor FAIL_SIG counts as fail.
  - Only the first trap cycle is captured; later sig changes are ignored.
- Trap is level-sensitive. A trap already high on the first RUN cycle is captured in that cycle.
- Transition to DONE occurs on the edge where all hart_done bits are set, including bits captured in the current cycle (zero-cycle latency from the last trap).
- On that edge:
  - pass = all hart_pass bits set.
  - fail = !pass.
  - first_fail = lowest h with hart_pass[h]=0, or 0 if none.
  - done = 1.
- Timeout: if cycles reaches TIMEOUT_CYCLES-1 in RUN and not all harts are done, then next edge: DONE with timeout=1, pass=0. fail=1 only if some captured hart already failed; first_fail is computed over captured harts only.
- Simultaneous completion and timeout on the same edge: completion wins, timeout=0.
- DONE: all outputs hold. Trap and sig are ignored.
- start in RUN or DONE: restart (clear and go to RUN). start has priority over completion in the same cycle.
- reset mid-RUN: immediate return to IDLE on that edge; reset has priority over start.
- Exactly one of pass, fail, timeout may be 1 without the others, except the timeout+fail combination above. All three are 0 while done=0.

Test Plan:
- NUM_HARTS=1: reset, start, trap at RUN cycle 100 with sig=32'h4F4B0A00 -> done=1, pass=1, fail=0, timeout=0, cycles=101 held.
- NUM_HARTS=4: harts trap at cycles 10/20/30/40; hart 2 sig=32'h4572720A, others PASS -> done at the cycle-40 edge, fail=1, first_fail=2, hart_pass=4'b1011.
- NUM_HARTS=2, TIMEOUT_CYCLES=50: hart 0 traps PASS at 5, hart 1 never traps -> done one edge after cycles=49, timeout=1, pass=0, fail=0, hart_done=2'b01.
- Last trap on the same cycle timeout expires -> timeout=0; verdict is from the signatures. Also: sig changes after capture -> verdict unchanged. Unknown sig 32'h12345678 -> fail.
- Reset asserted mid-RUN together with start -> IDLE, all outputs 0. Then start during DONE -> flags clear and cycles restarts from 0.
- Trap high before start -> captured on the first RUN cycle; done asserted after one RUN cycle when NUM_HARTS=1.

Source files
------------

// File: rtl/test_monitor.sv
// End-of-test monitor for a multi-hart core array: latches each hart's result
// signature on its first trap and produces a pass / fail / timeout verdict.
module test_monitor #(
    parameter int          NUM_HARTS      = 1,
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] PASS_SIG       = 32'h4F4B0A00,
    parameter logic [31:0] FAIL_SIG       = 32'h4572720A
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_HARTS-1:0]      trap,
    input  logic [32*NUM_HARTS-1:0]   sig,
    output logic [NUM_HARTS-1:0]      hart_done,
    output logic [NUM_HARTS-1:0]      hart_pass,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic                      timeout,
    output logic [3:0]                first_fail,
    output logic [CNT_W-1:0]          cycles,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [NUM_HARTS-1:0]   sig_is_pass;
    logic [NUM_HARTS-1:0]   capture;
    logic [NUM_HARTS-1:0]   done_nxt;
    logic [NUM_HARTS-1:0]   pass_nxt;
    logic [NUM_HARTS-1:0]   bad_nxt;
    logic                   all_done;
    logic                   timeout_hit;
    logic [3:0]             first_bad;
    logic [CNT_W-1:0]       cycles_inc;

    // FAIL_SIG only documents the expected failure word: any non-PASS signature fails.
    logic unused_fail_sig;
    assign unused_fail_sig = ^FAIL_SIG;

    assign dbg_state = state;

    always_comb begin
        sig_is_pass = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            sig_is_pass[h] = (sig[32*h +: 32] == PASS_SIG);
        end
    end

    // Next-cycle view includes harts trapping right now, so completion has no extra latency.
    assign capture     = trap & ~hart_done;
    assign done_nxt    = hart_done | capture;
    assign pass_nxt    = hart_pass | (capture & sig_is_pass);
    assign bad_nxt     = done_nxt & ~pass_nxt;
    assign all_done    = &done_nxt;
    assign timeout_hit = (cycles >= LAST_CYCLE);
    assign cycles_inc  = (&cycles) ? cycles : cycles + 1'b1;

    always_comb begin
        first_bad = '0;
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (bad_nxt[h]) begin
                first_bad = 4'(h);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cycles     <= '0;
            hart_done  <= '0;
            hart_pass  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            first_fail <= '0;
        end else if (start) begin
            // Start restarts from any state and beats a completion in the same cycle.
            state      <= RUN;
            cycles     <= '0;
            hart_done  <= '0;
            hart_pass  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            first_fail <= '0;
        end else if (state == RUN) begin
            cycles    <= cycles_inc;
            hart_done <= done_nxt;
            hart_pass <= pass_nxt;
            if (all_done) begin
                state      <= DONE;
                done       <= 1'b1;
                pass       <= &pass_nxt;
                fail       <= ~(&pass_nxt);
                timeout    <= 1'b0;
                first_fail <= first_bad;
            end else if (timeout_hit) begin
                state      <= DONE;
                done       <= 1'b1;
                pass       <= 1'b0;
                fail       <= |bad_nxt;
                timeout    <= 1'b1;
                first_fail <= first_bad;
            end
        end
    end

endmodule
